param_proc_core: RTL and testbench
==================================

Name: param_proc_core

Overview:
- Parametrised successor to the 16-bit simple processor datapath.
- Multi-cycle core that fetches 16-bit instructions over a valid handshake and executes conditional ALU, load/store, jump, branch and halt operations.
- Data width, program-counter width and data-memory address width are parameters.
- Instruction and data memories are external, with variable latency; the core stalls on both handshakes. It sits between program RAM and data RAM in the top-level.

Parameters:
- DATA_W, 16, register/ALU/data-memory word width (>=8)
- PC_W, 10, program counter width; instruction address space 2^PC_W
- DMEM_AW, 7, data-memory address width (<=DATA_W)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin execution from IDLE
- imem_req  out  1  instruction fetch request, held until imem_vld
- imem_addr  out  PC_W  fetch address (=pc)
- imem_rdata  in  16  instruction word
- imem_vld  in  1  instruction valid, sampled only while imem_req=1
- dmem_req  out  1  data access request, held until dmem_vld
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  DMEM_AW  =rs1[DMEM_AW-1:0]
- dmem_wdata  out  DATA_W  =rs2 value
- dmem_rdata  in  DATA_W  load data, valid with dmem_vld
- dmem_vld  in  1  access complete
- result  out  DATA_W  last value written to the register file
- zero/negative/carry/overflow  out  1 each  flag register
- retire  out  1  one-cycle pulse per completed instruction, including condition-failed ones
- halted  out  1  core in HALT
- busy  out  1  state != IDLE and != HALT

Behaviour:
- Instruction fields:
  - cond[15:14]: 00 always, 01 Z=1, 10 N=1, 11 C=1
  - op[13:10]
  - rd[9:7], rs1[6:4], rs2[3:1]
  - imm7[6:0]
- Eight DATA_W registers; r0 is writable.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SHL (rs1<<1, C = shifted-out bit), 0110 SHR (logical, C = bit0)
  - 0111 LDI: rd = zero-extended imm7
  - 1000 LD: rd = dmem[rs1]
  - 1001 ST: dmem[rs1] = rs2
  - 1010 JMP: pc = rs1[PC_W-1:0]
  - 1011 BR: pc = pc_of_instr + sign-extended imm7, modulo 2^PC_W
  - 1111 HALT
  - all others NOP
- Flags are updated only by ops 0000-0110.
  - Z = result==0; N = result MSB
  - ADD: C = carry out, V = signed overflow
  - SUB: computes rs1-rs2; C = no-borrow (rs1>=rs2 unsigned), V = signed overflow
  - Logic ops: C and V cleared
  - Shifts: V cleared
- State machine:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1. On imem_vld, latch the instruction -> DECODE.
  - DECODE: read registers, evaluate cond against the current flags. If cond fails: pc += 1, retire -> FETCH. If op = HALT -> HALT. Otherwise -> EXEC.
  - EXEC: ALU ops and LDI -> WB. LD/ST -> MEM. JMP/BR load pc, retire -> FETCH. NOP: pc += 1, retire -> FETCH.
  - MEM: dmem_req=1, dmem_we per op. On dmem_vld: ST retires, pc += 1 -> FETCH; LD latches data -> WB.
  - WB: write rd, update result and flags (ALU ops only), pc += 1, retire -> FETCH.
  - HALT: halted=1. Leaves only on rst; start ignored.
- Latency with zero-wait memories (imem_vld/dmem_vld high in the first request cycle):
  - ALU/LDI: 4 cycles per instruction
  - LD: 5 cycles; ST: 4 cycles
  - JMP/BR/NOP: 3 cycles; condition-fail: 2 cycles
- Each wait cycle adds one. imem_addr, dmem_addr, dmem_wdata and dmem_we are stable while the request is held.
- pc increment wraps from 2^PC_W-1 to 0.
- start is ignored outside IDLE.
- Reset, asynchronous and possibly mid-operation:
  - state = IDLE; pc = 0; all registers, flags and result = 0
  - imem_req = dmem_req = retire = halted = busy = 0
  - An in-flight memory request is abandoned, and its late vld is ignored because req=0.

Decomposition:
- Package param_proc_pkg holds:
  - opcode localparams
  - cond-code constants
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
  - instruction field bit positions
- Sub-module param_proc_alu is combinational: op, a, b, DATA_W -> result plus Z/N/C/V.

Test Plan:
- DATA_W=16, zero-wait. Program LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT -> r3=2, result=0x0002, Z=0, C=1; halted after 4+4+4+2 cycles of execution; retire pulses 3 times.
- SUB r0,r1,r1 (r1=7), then cond=01 ADD r4,r1,r1 -> Z=1, r4=14. Repeat with preceding result nonzero -> ADD skipped: 2 cycles, retire pulses, pc+1, r4 unchanged.
- ST with r1=0x0012 (addr), r2=0xBEEF; dmem_vld delayed 3 cycles -> dmem_req held 4 cycles, dmem_addr=0x12, dmem_wdata=0xBEEF stable. Then LD r5 from 0x12 -> r5=0xBEEF.
- PC_W=4: pc=15 executing NOP -> next imem_addr=0. BR imm7=0x7E at pc=1 -> imem_addr=15.
- DATA_W=8: ADD 0x7F+0x01 -> result 0x80, V=1, N=1, C=0. ADD 0xFF+0x01 -> 0x00, Z=1, C=1.
- Assert rst during a MEM wait with dmem_req=1 -> all outputs 0 immediately. Late dmem_vld ignored. start then restarts fetch at imem_addr=0.

Source files
------------

// File: rtl/param_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_proc_pkg
// Brief    : Opcodes, condition codes, FSM encoding and instruction fields
//            shared by the parametrised processor core and its ALU.
// Revision : 1.0 - initial release
// ============================================================================
package param_proc_pkg;

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_shl  = 4'b0101;
    localparam logic [3:0] c_op_shr  = 4'b0110;
    localparam logic [3:0] c_op_ldi  = 4'b0111;
    localparam logic [3:0] c_op_ld   = 4'b1000;
    localparam logic [3:0] c_op_st   = 4'b1001;
    localparam logic [3:0] c_op_jmp  = 4'b1010;
    localparam logic [3:0] c_op_br   = 4'b1011;
    localparam logic [3:0] c_op_halt = 4'b1111;

    localparam logic [1:0] c_cond_al = 2'b00;
    localparam logic [1:0] c_cond_z  = 2'b01;
    localparam logic [1:0] c_cond_n  = 2'b10;
    localparam logic [1:0] c_cond_c  = 2'b11;

    typedef enum logic [2:0] {
        c_st_idle   = 3'd0,
        c_st_fetch  = 3'd1,
        c_st_decode = 3'd2,
        c_st_exec   = 3'd3,
        c_st_mem    = 3'd4,
        c_st_wb     = 3'd5,
        c_st_halt   = 3'd6
    } state_t;

    localparam int c_cond_msb = 15;
    localparam int c_cond_lsb = 14;
    localparam int c_op_msb   = 13;
    localparam int c_op_lsb   = 10;
    localparam int c_rd_msb   = 9;
    localparam int c_rd_lsb   = 7;
    localparam int c_rs1_msb  = 6;
    localparam int c_rs1_lsb  = 4;
    localparam int c_rs2_msb  = 3;
    localparam int c_rs2_lsb  = 1;
    localparam int c_imm_msb  = 6;
    localparam int c_imm_lsb  = 0;

    function automatic logic cond_pass(input logic [1:0] cond, input logic z,
                                       input logic n, input logic c);
        logic ok;
        case (cond)
            c_cond_al: ok = 1'b1;
            c_cond_z:  ok = z;
            c_cond_n:  ok = n;
            c_cond_c:  ok = c;
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Ops 0000-0110 are the only ones that touch the flag register
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= c_op_shr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_proc_alu.sv
`default_nettype none
// ============================================================================
// Module   : param_proc_alu
// Brief    : Combinational DATA_W-wide ALU producing result and Z/N/C/V.
// Revision : 1.0 - initial release
// ============================================================================
module param_proc_alu
    import param_proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y,
    output logic              o_z,
    output logic              o_n,
    output logic              o_c,
    output logic              o_v
);

    localparam int c_msb = DATA_W - 1;

    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum = '0;
        o_y   = '0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            c_op_add: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b};
                o_y   = w_sum[c_msb:0];
                o_c   = w_sum[DATA_W];
                o_v   = (i_a[c_msb] == i_b[c_msb]) && (o_y[c_msb] != i_a[c_msb]);
            end
            c_op_sub: begin
                // a + ~b + 1: carry out is the no-borrow indication
                w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};
                o_y   = w_sum[c_msb:0];
                o_c   = w_sum[DATA_W];
                o_v   = (i_a[c_msb] != i_b[c_msb]) && (o_y[c_msb] != i_a[c_msb]);
            end
            c_op_and: o_y = i_a & i_b;
            c_op_or:  o_y = i_a | i_b;
            c_op_xor: o_y = i_a ^ i_b;
            c_op_shl: begin
                o_y = {i_a[c_msb-1:0], 1'b0};
                o_c = i_a[c_msb];
            end
            c_op_shr: begin
                o_y = {1'b0, i_a[c_msb:1]};
                o_c = i_a[0];
            end
            default: ;
        endcase
    end

    assign o_z = (o_y == '0);
    assign o_n = o_y[c_msb];

endmodule
`default_nettype wire

// File: rtl/param_proc_core.sv
`default_nettype none
// ============================================================================
// Module   : param_proc_core
// Brief    : Multi-cycle parametrised processor with handshaked instruction
//            and data memory ports and conditional execution.
// Revision : 1.0 - initial release
// ============================================================================
module param_proc_core
    import param_proc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 10,
    parameter int DMEM_AW = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_vld,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_vld,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow,
    output logic               retire,
    output logic               halted,
    output logic               busy
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_rf [8];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_ld;
    logic [DATA_W-1:0] r_result;
    logic              r_z, r_n, r_c, r_v;
    logic              r_imem_req, r_dmem_req, r_dmem_we;
    logic              r_retire, r_halted, r_busy;

    logic [1:0]        w_cond;
    logic [3:0]        w_op;
    logic [2:0]        w_rd, w_rs1, w_rs2;
    logic [6:0]        w_imm;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_z, w_alu_n, w_alu_c, w_alu_v;
    logic [DATA_W-1:0] w_wb_data;
    logic [PC_W-1:0]   w_pc_inc, w_br_pc, w_jmp_pc;

    assign w_cond = r_instr[c_cond_msb:c_cond_lsb];
    assign w_op   = r_instr[c_op_msb:c_op_lsb];
    assign w_rd   = r_instr[c_rd_msb:c_rd_lsb];
    assign w_rs1  = r_instr[c_rs1_msb:c_rs1_lsb];
    assign w_rs2  = r_instr[c_rs2_msb:c_rs2_lsb];
    assign w_imm  = r_instr[c_imm_msb:c_imm_lsb];

    assign w_pc_inc = r_pc + PC_W'(1);
    // r_pc still holds the branch's own address until it retires
    assign w_br_pc  = r_pc + PC_W'($signed(w_imm));

    generate
        if (PC_W <= DATA_W) begin : g_jmp_narrow
            assign w_jmp_pc = r_a[PC_W-1:0];
        end else begin : g_jmp_wide
            assign w_jmp_pc = {{(PC_W-DATA_W){1'b0}}, r_a};
        end
    endgenerate

    param_proc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op (w_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_alu_y),
        .o_z  (w_alu_z),
        .o_n  (w_alu_n),
        .o_c  (w_alu_c),
        .o_v  (w_alu_v)
    );

    always_comb begin
        w_wb_data = w_alu_y;
        if (w_op == c_op_ldi) begin
            w_wb_data = {{(DATA_W-7){1'b0}}, w_imm};
        end else if (w_op == c_op_ld) begin
            w_wb_data = r_ld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_pc       <= '0;
            r_instr    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_ld       <= '0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_retire   <= 1'b0;
            r_halted   <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_fetch;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_fetch: begin
                    if (imem_vld) begin
                        r_instr    <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    r_a <= r_rf[w_rs1];
                    r_b <= r_rf[w_rs2];
                    if (!cond_pass(w_cond, r_z, r_n, r_c)) begin
                        r_pc       <= w_pc_inc;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= c_st_fetch;
                    end else if (w_op == c_op_halt) begin
                        r_state  <= c_st_halt;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (is_alu_op(w_op) || w_op == c_op_ldi) begin
                        r_state <= c_st_wb;
                    end else if (w_op == c_op_ld || w_op == c_op_st) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_op == c_op_st);
                        r_state    <= c_st_mem;
                    end else begin
                        if (w_op == c_op_jmp) begin
                            r_pc <= w_jmp_pc;
                        end else if (w_op == c_op_br) begin
                            r_pc <= w_br_pc;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= c_st_fetch;
                    end
                end
                c_st_mem: begin
                    if (dmem_vld) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_pc       <= w_pc_inc;
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
                        end else begin
                            r_ld    <= dmem_rdata;
                            r_state <= c_st_wb;
                        end
                    end
                end
                c_st_wb: begin
                    r_rf[w_rd] <= w_wb_data;
                    r_result   <= w_wb_data;
                    if (is_alu_op(w_op)) begin
                        r_z <= w_alu_z;
                        r_n <= w_alu_n;
                        r_c <= w_alu_c;
                        r_v <= w_alu_v;
                    end
                    r_pc       <= w_pc_inc;
                    r_retire   <= 1'b1;
                    r_imem_req <= 1'b1;
                    r_state    <= c_st_fetch;
                end
                c_st_halt: r_state <= c_st_halt;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_a[DMEM_AW-1:0];
    assign dmem_wdata = r_b;
    assign result     = r_result;
    assign zero       = r_z;
    assign negative   = r_n;
    assign carry      = r_c;
    assign overflow   = r_v;
    assign retire     = r_retire;
    assign halted     = r_halted;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_param_proc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_proc_core
// Brief    : Directed self-checking bench for a 16-bit and an 8-bit/4-bit-PC
//            instance of param_proc_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_proc_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start8 = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance and its memory models
    logic        imem_req, dmem_req, dmem_we, dmem_vld, retire, halted, busy;
    logic [9:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [6:0]  dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata, result;
    logic        zero, negative, carry, overflow;
    logic [15:0] prog [1024];
    logic [15:0] dmem [128];
    int          dwait = 0;
    int          dcnt = 0;
    logic        force_dvld = 1'b0;
    logic        pre_we = 1'b0;
    logic [6:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign imem_rdata = prog[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_vld   = force_dvld | (dmem_req && (dcnt >= dwait));

    always @(posedge clk) begin
        if (dmem_req && !dmem_vld) dcnt <= dcnt + 1;
        else                       dcnt <= 0;
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (dmem_req && dmem_vld && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    param_proc_core #(.DATA_W(16), .PC_W(10), .DMEM_AW(7)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_vld(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_vld(dmem_vld),
        .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
        .retire(retire), .halted(halted), .busy(busy)
    );

    // 8-bit data / 4-bit PC instance
    logic        imem_req8, dmem_req8, dmem_we8, retire8, halted8, busy8;
    logic [3:0]  imem_addr8;
    logic [6:0]  dmem_addr8;
    logic [7:0]  dmem_wdata8, result8;
    logic        zero8, negative8, carry8, overflow8;
    logic [15:0] prog8 [16];
    logic [15:0] imem_rdata8;
    assign imem_rdata8 = prog8[imem_addr8];

    param_proc_core #(.DATA_W(8), .PC_W(4), .DMEM_AW(7)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8), .imem_vld(imem_req8),
        .dmem_req(dmem_req8), .dmem_we(dmem_we8), .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8),
        .dmem_rdata(8'h00), .dmem_vld(dmem_req8),
        .result(result8), .zero(zero8), .negative(negative8), .carry(carry8), .overflow(overflow8),
        .retire(retire8), .halted(halted8), .busy(busy8)
    );

    int total = 0;
    int bad = 0;

    function automatic logic [15:0] mk(input logic [1:0] cond, input logic [3:0] op,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2);
        return {cond, op, rd, rs1, rs2, 1'b0};
    endfunction

    function automatic logic [15:0] mki(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [6:0] imm);
        return {2'b00, op, rd, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input bit sel);
        @(negedge clk);
        if (sel) start8 = 1'b1;
        else     start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_retire(input bit sel, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(sel ? retire8 : retire) && cyc < 200);
        check("retire_within_bound", 32'(cyc < 200), 1);
    endtask

    task automatic run_to_halt(input bit sel, output int cyc, output int nret);
        cyc  = 0;
        nret = 0;
        while (!(sel ? halted8 : halted) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sel ? retire8 : retire) nret++;
        end
        check("halt_within_bound", 32'(cyc < 2000), 1);
    endtask

    task automatic clear_progs();
        for (int i = 0; i < 1024; i++) prog[i] = mk(2'b00, 4'hF, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 16; i++)   prog8[i] = mk(2'b00, 4'hC, 3'd0, 3'd0, 3'd0);
    endtask

    initial begin
        int cyc;
        int nret;
        int held;

        clear_progs();
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_result", result, 0);
        rst = 1'b0;

        // LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT
        prog[0] = mki(4'h7, 3'd1, 7'd5);
        prog[1] = mki(4'h7, 3'd2, 7'd3);
        prog[2] = mk(2'b00, 4'h1, 3'd3, 3'd1, 3'd2);
        prog[3] = mk(2'b00, 4'hF, 3'd0, 3'd0, 3'd0);
        check("idle_before_start", busy, 0);
        kick(1'b0);
        check("busy_after_start", busy, 1);
        run_to_halt(1'b0, cyc, nret);
        check("sub_cycles", cyc, 14);
        check("sub_retires", nret, 3);
        check("sub_result", result, 16'h0002);
        check("sub_zero", zero, 0);
        check("sub_carry", carry, 1);
        check("halt_busy", busy, 0);
        check("halt_imem_req", imem_req, 0);
        kick(1'b0);
        check("halt_ignores_start", halted, 1);

        // Conditional execution on Z
        do_reset();
        clear_progs();
        prog[0] = mki(4'h7, 3'd1, 7'd7);
        prog[1] = mk(2'b00, 4'h1, 3'd0, 3'd1, 3'd1);
        prog[2] = mk(2'b01, 4'h0, 3'd4, 3'd1, 3'd1);
        prog[3] = mki(4'h7, 3'd5, 7'd1);
        prog[4] = mk(2'b01, 4'h0, 3'd4, 3'd4, 3'd4);
        prog[5] = mk(2'b00, 4'h3, 3'd6, 3'd4, 3'd4);
        kick(1'b0);
        wait_retire(1'b0, cyc);
        check("ldi_cycles", cyc, 4);
        wait_retire(1'b0, cyc);
        check("sub_self_zero", zero, 1);
        check("sub_self_result", result, 0);
        wait_retire(1'b0, cyc);
        check("condz_add_result", result, 16'd14);
        check("condz_add_zero", zero, 0);
        wait_retire(1'b0, cyc);
        check("ldi_r5_result", result, 1);
        wait_retire(1'b0, cyc);
        check("skip_cycles", cyc, 2);
        check("skip_pc", imem_addr, 5);
        check("skip_result", result, 1);
        run_to_halt(1'b0, cyc, nret);
        check("r4_unchanged", result, 16'd14);
        check("or_retires", nret, 1);

        // Store/load with a 3-cycle data wait
        do_reset();
        clear_progs();
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 7'h20; pre_data = 16'hBEEF;
        @(negedge clk);
        pre_addr = 7'h12; pre_data = 16'h0000;
        @(negedge clk);
        pre_we = 1'b0;
        dwait = 3;
        prog[0] = mki(4'h7, 3'd1, 7'h20);
        prog[1] = mk(2'b00, 4'h8, 3'd2, 3'd1, 3'd0);
        prog[2] = mki(4'h7, 3'd1, 7'h12);
        prog[3] = mk(2'b00, 4'h9, 3'd0, 3'd1, 3'd2);
        prog[4] = mk(2'b00, 4'h8, 3'd5, 3'd1, 3'd0);
        kick(1'b0);
        cyc = 0;
        while (!(dmem_req && dmem_we) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("st_req_seen", 32'(cyc < 200), 1);
        held = 0;
        while (dmem_req && held < 20) begin
            check("st_addr", dmem_addr, 7'h12);
            check("st_wdata", dmem_wdata, 16'hBEEF);
            check("st_we", dmem_we, 1);
            held++;
            @(negedge clk);
        end
        check("st_req_held", held, 4);
        check("st_mem_written", dmem[7'h12], 16'hBEEF);
        run_to_halt(1'b0, cyc, nret);
        check("ld_result", result, 16'hBEEF);
        check("ld_no_flags", zero, 0);

        // Asynchronous reset in the middle of a data wait
        do_reset();
        clear_progs();
        dwait = 1000;
        prog[0] = mki(4'h7, 3'd1, 7'h12);
        prog[1] = mk(2'b00, 4'h8, 3'd3, 3'd1, 3'd0);
        kick(1'b0);
        cyc = 0;
        while (!dmem_req && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("ld_req_seen", dmem_req, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dmem_req", dmem_req, 0);
        check("arst_imem_req", imem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_dmem_addr", dmem_addr, 0);
        check("arst_retire", retire, 0);
        @(negedge clk);
        rst = 1'b0;
        force_dvld = 1'b1;
        repeat (3) @(negedge clk);
        check("late_vld_busy", busy, 0);
        check("late_vld_result", result, 0);
        check("late_vld_imem_req", imem_req, 0);
        force_dvld = 1'b0;
        dwait = 0;
        kick(1'b0);
        check("restart_imem_req", imem_req, 1);
        check("restart_imem_addr", imem_addr, 0);
        run_to_halt(1'b0, cyc, nret);
        check("restart_ld_result", result, 16'hBEEF);

        // 4-bit PC: branch backwards past 0, NOP wraps 15 -> 0
        do_reset();
        clear_progs();
        prog8[1] = mki(4'hB, 3'd0, 7'h7E);
        kick(1'b1);
        wait_retire(1'b1, cyc);
        check("pc4_nop_cycles", cyc, 3);
        check("pc4_after_nop", imem_addr8, 1);
        wait_retire(1'b1, cyc);
        check("pc4_br_target", imem_addr8, 15);
        wait_retire(1'b1, cyc);
        check("pc4_wrap", imem_addr8, 0);

        // 8-bit ALU flags
        do_reset();
        clear_progs();
        prog8[0] = mki(4'h7, 3'd1, 7'h7F);
        prog8[1] = mki(4'h7, 3'd2, 7'h01);
        prog8[2] = mk(2'b00, 4'h0, 3'd3, 3'd1, 3'd2);
        prog8[3] = mk(2'b00, 4'h5, 3'd4, 3'd1, 3'd0);
        prog8[4] = mk(2'b00, 4'h3, 3'd4, 3'd4, 3'd2);
        prog8[5] = mk(2'b00, 4'h0, 3'd5, 3'd4, 3'd2);
        prog8[6] = mk(2'b00, 4'hF, 3'd0, 3'd0, 3'd0);
        kick(1'b1);
        repeat (3) wait_retire(1'b1, cyc);
        check("add8_ovf_result", result8, 8'h80);
        check("add8_ovf_v", overflow8, 1);
        check("add8_ovf_n", negative8, 1);
        check("add8_ovf_c", carry8, 0);
        run_to_halt(1'b1, cyc, nret);
        check("add8_wrap_result", result8, 8'h00);
        check("add8_wrap_z", zero8, 1);
        check("add8_wrap_c", carry8, 1);
        check("add8_wrap_v", overflow8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
